// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and datapath widths.
package cpu_pkg;

    localparam int unsigned PC_W     = 10;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RESET_PC = 0;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch FSM with a valid/ready handoff to decode.
// Build option: define PC_FETCH_PERF_EN to build the retired-instruction counter.
module pc_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned DataSize = INSTR_W,
    parameter int unsigned PcSize   = PC_W,
    parameter int unsigned ResetPc  = RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PcSize-1:0]   next_pc,
    input  logic                ir_ready,
    input  logic                halt,
    input  logic                im_ack,
    input  logic [DataSize-1:0] im_data,
    output logic                im_req,
    output logic [PcSize-1:0]   im_addr,
    output logic [PcSize-1:0]   current_pc,
    output logic [DataSize-1:0] ir,
    output logic                ir_valid,
    output logic                halted,
    output logic                misalign_err,
    output logic [31:0]         retire_count
);

    fetch_state_t        state_q, state_d;
    logic [PcSize-1:0]   pc_q, pc_d;
    logic [DataSize-1:0] ir_q, ir_d;
    logic                ir_valid_q, ir_valid_d;
    logic                im_req_q, im_req_d;
    logic                halted_q, halted_d;
    logic                misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        im_req_d   = im_req_q;
        halted_d   = halted_q;
        misalign_d = misalign_q;
        case (state_q)
            S_BOOT: begin
                state_d  = S_REQ;
                im_req_d = 1'b1;
            end
            S_REQ: begin
                if (im_ack) begin
                    ir_d       = im_data;
                    ir_valid_d = 1'b1;
                    im_req_d   = 1'b0;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // Halt takes priority over a misaligned target on the same retire.
                if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (next_pc[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        halted_d   = 1'b1;
                        state_d    = S_HALT;
                    end else begin
                        pc_d     = next_pc;
                        im_req_d = 1'b1;
                        state_d  = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_BOOT;
            pc_q       <= PcSize'(ResetPc);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            im_req_q   <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            im_req_q   <= im_req_d;
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    assign im_req       = im_req_q;
    assign im_addr      = pc_q;
    assign current_pc   = pc_q;
    assign ir           = ir_q;
    assign ir_valid     = ir_valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

`ifdef PC_FETCH_PERF_EN
    logic        retire;
    logic [31:0] retire_count_q, retire_count_d;

    // Every accepted retire counts, including the one that halts fetch.
    assign retire = (state_q == S_HOLD) && ir_ready;

    always_comb begin
        retire_count_d = retire_count_q;
        if (retire) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch rules.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  next_pc = '0;
    logic        ir_ready = 1'b0;
    logic        halt = 1'b0;
    logic        im_ack = 1'b0;
    logic [31:0] im_data = '0;
    logic        im_req;
    logic [9:0]  im_addr;
    logic [9:0]  current_pc;
    logic [31:0] ir;
    logic        ir_valid;
    logic        halted;
    logic        misalign_err;
    logic [31:0] retire_count;

    int vectors = 0;
    int miscompares = 0;

    pc_fetch #(.DataSize(32), .PcSize(10), .ResetPc(0)) dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .ir_ready(ir_ready), .halt(halt),
        .im_ack(im_ack), .im_data(im_data), .im_req(im_req), .im_addr(im_addr),
        .current_pc(current_pc), .ir(ir), .ir_valid(ir_valid), .halted(halted),
        .misalign_err(misalign_err), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    // Model: what the fetch unit must present after each edge, from its contract.
    bit          m_boot = 1'b1;
    bit          m_req = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_mis = 1'b0;
    int unsigned m_pc = 0;
    logic [31:0] m_ir = '0;
    logic [31:0] m_cnt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_boot = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0;
            m_mis = 1'b0; m_pc = 0; m_ir = '0; m_cnt = '0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_req  = 1'b1;
        end else if (m_halted) begin
            // fetch stopped until reset
        end else if (m_req) begin
            if (im_ack) begin
                m_ir = im_data; m_valid = 1'b1; m_req = 1'b0;
            end
        end else if (m_valid && ir_ready) begin
            m_valid = 1'b0;
            m_cnt   = m_cnt + 1;
            if (halt) m_halted = 1'b1;
            else if (next_pc % 4 != 0) begin m_halted = 1'b1; m_mis = 1'b1; end
            else begin m_pc = next_pc; m_req = 1'b1; end
        end
    end

    function automatic logic [31:0] exp_count();
`ifdef PC_FETCH_PERF_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    always @(negedge clk) begin
        vectors++;
        if (im_req !== m_req || im_addr !== 10'(m_pc) || current_pc !== 10'(m_pc) ||
            ir_valid !== m_valid || halted !== m_halted || misalign_err !== m_mis ||
            retire_count !== exp_count() || ir !== m_ir) begin
            miscompares++;
            $display("FAIL model t=%0t dut req=%b pc=%0d ir=%h v=%b h=%b mis=%b cnt=%0d | exp req=%b pc=%0d ir=%h v=%b h=%b mis=%b cnt=%0d",
                     $time, im_req, current_pc, ir, ir_valid, halted, misalign_err, retire_count,
                     m_req, m_pc, m_ir, m_valid, m_halted, m_mis, exp_count());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic fetch_now(input logic [31:0] word);
        im_ack = 1'b1; im_data = word;
        tick();
        im_ack = 1'b0;
    endtask

    task automatic retire_to(input logic [9:0] target, input logic h);
        ir_ready = 1'b1; next_pc = target; halt = h;
        tick();
        ir_ready = 1'b0; halt = 1'b0;
    endtask

    initial begin
        tick(2);
        check("reset_pc", 32'(current_pc), 32'd0);
        check("reset_req", 32'(im_req), 32'd0);
        check("reset_valid", 32'(ir_valid), 32'd0);
        check("reset_cnt", retire_count, 32'd0);

        rst = 1'b0;
        tick();
        check("boot_req", 32'(im_req), 32'd1);
        check("boot_addr", 32'(im_addr), 32'd0);
        fetch_now(32'hDEAD0001);
        check("first_ir", ir, 32'hDEAD0001);
        check("first_valid", 32'(ir_valid), 32'd1);
        check("first_req_drop", 32'(im_req), 32'd0);

        retire_to(10'd8, 1'b0);
        check("retire_pc", 32'(current_pc), 32'd8);
        check("retire_valid", 32'(ir_valid), 32'd0);
        check("retire_addr", 32'(im_addr), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_req", 32'(im_req), 32'd1);
            check("wait_addr", 32'(im_addr), 32'd8);
            check("wait_valid", 32'(ir_valid), 32'd0);
        end
        fetch_now(32'h0000_1234);
        check("delayed_ir", ir, 32'h0000_1234);
        tick(2);
        check("hold_pc", 32'(current_pc), 32'd8);
        check("hold_valid", 32'(ir_valid), 32'd1);

        retire_to(10'd12, 1'b0);
        fetch_now(32'hA5A5_0003);
        retire_to(10'd16, 1'b0);
        fetch_now(32'hA5A5_0004);
        retire_to(10'd6, 1'b1);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_mis", 32'(misalign_err), 32'd0);
        check("halt_pc", 32'(current_pc), 32'd16);
`ifdef PC_FETCH_PERF_EN
        check("halt_cnt", retire_count, 32'd4);
`else
        check("halt_cnt", retire_count, 32'd0);
`endif
        im_ack = 1'b1;
        tick(3);
        im_ack = 1'b0;
        check("halt_req", 32'(im_req), 32'd0);
        check("halt_valid", 32'(ir_valid), 32'd0);

        rst = 1'b1;
        #1;
        check("rst_pc", 32'(current_pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cnt", retire_count, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("restart_addr", 32'(im_addr), 32'd0);
        check("restart_req", 32'(im_req), 32'd1);
        fetch_now(32'h0BAD_F00D);
        retire_to(10'd6, 1'b0);
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_halted", 32'(halted), 32'd1);
        check("mis_pc", 32'(current_pc), 32'd0);
        tick(3);
        check("mis_req", 32'(im_req), 32'd0);

        // Randomized traffic; reset occasionally and whenever fetch is stuck halted.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            im_ack   = ($urandom_range(0, 99) < 45);
            im_data  = $urandom();
            ir_ready = ($urandom_range(0, 99) < 40);
            halt     = ($urandom_range(0, 99) < 4);
            next_pc  = 10'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 99) < 8) next_pc = 10'($urandom());
            if ($urandom_range(0, 99) < 5) next_pc = 10'd0;
            if ($urandom_range(0, 999) < 3 || (m_halted && $urandom_range(0, 9) == 0))
                rst = 1'b1;
            else
                rst = 1'b0;
            tick();
        end
        rst = 1'b0; im_ack = 1'b0; ir_ready = 1'b0; halt = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
